ch9350_keytx: RTL
=================

CH9350_KEYTX -- requirements
Module: ch9350_keytx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 312, meaning i_clk cycles per UART bit (12 MHz / 38400 baud).
REQ-002 SHALL have parameter GAP_BITS, default 10, meaning idle bit-times on o_txd between the press frame and the release frame.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock, 12 MHz.
REQ-004 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_data, input, 8 bits: ASCII character to type.
REQ-006 SHALL have port i_data_valid, input, 1 bit: i_data is valid.
REQ-007 SHALL have port o_data_ready, output, 1 bit: the block can accept a character.
REQ-008 SHALL have port o_txd, output, 1 bit: UART 8N1 line to the CH9350, idle high.
REQ-009 SHALL have port o_busy, output, 1 bit: a frame or gap is in progress.
REQ-010 SHALL have port o_unmapped, output, 1 bit: one-cycle pulse when an accepted character has no mapping.

Function
REQ-011 SHALL accept a character on a rising edge where i_data_valid and o_data_ready are both 1; o_data_ready SHALL be 1 only in IDLE.
REQ-012 SHALL map characters as follows (all other mappings SHALL use modifier 0x00):
- 'a'..'z' to 0x04..0x1D, modifier 0x00.
- 'A'..'Z' to 0x04..0x1D, modifier 0x02.
- '1'..'9' to 0x1E..0x26, '0' to 0x27.
- 0x0D to 0x28, 0x1B to 0x29, 0x08 to 0x2A, 0x09 to 0x2B, 0x20 to 0x2C.
REQ-013 SHALL handle an unmapped character by pulsing o_unmapped for the cycle after acceptance, sending no frame and returning to IDLE.
REQ-014 SHALL use frame format: 0x57, 0xAB, 0x01, then an 8-byte HID report (modifier, 0x00, usage, 0x00 x5); 11 bytes, sent LSB-first.
REQ-015 SHALL encode each byte as start bit 0, 8 data bits, stop bit 1, each bit held for exactly CLKS_PER_BIT cycles, with no idle between bytes of a frame.
REQ-016 SHALL send, for a mapped character, the press frame, then GAP_BITS*CLKS_PER_BIT cycles of o_txd=1, then the release frame (modifier 0x00, usage 0x00).
REQ-017 SHALL use states IDLE -> LOAD -> SEND -> GAP -> SEND -> DONE -> IDLE; LOAD goes to IDLE instead when the character is unmapped.
REQ-018 SHALL drive o_txd low for the first start bit from the second rising edge after acceptance (latency 2 cycles).
REQ-019 SHALL assert o_busy from the edge after acceptance until the release frame's final stop bit completes; DONE SHALL last one cycle, and o_data_ready SHALL rise the cycle after DONE.
REQ-020 SHALL latch the character on acceptance; changes to i_data or i_data_valid during a transfer SHALL have no effect.
REQ-021 SHALL keep i_data_valid held high across DONE from being accepted until o_data_ready is 1; there is no back-to-back bypass.
REQ-022 SHALL use a bit counter wide enough for CLKS_PER_BIT-1 and a gap counter wide enough for GAP_BITS*CLKS_PER_BIT-1.

Reset
REQ-023 SHALL, while i_rst is 1, set: state IDLE, o_txd=1, o_busy=0, o_unmapped=0, o_data_ready=0; o_data_ready SHALL become 1 the cycle after i_rst falls.
REQ-024 SHALL, on reset mid-frame, abort the frame immediately with o_txd=1 on the next edge; no partial byte SHALL be resumed.

Configuration
REQ-025 SHALL, with macro CH9350_KEYTX_CHECKSUM_EN defined, append a 12th byte to each frame equal to the sum mod 256 of the 8 report bytes.
REQ-026 SHALL, without CH9350_KEYTX_CHECKSUM_EN, send 11-byte frames and contain no checksum logic.

Verification
REQ-027 SHALL verify: send 'a' (0x61) -> press 57 AB 01 00 00 04 00 00 00 00 00, 3120 idle cycles, release 57 AB 01 00 00 00 00 00 00 00 00.
REQ-028 SHALL verify: send 'Z' (0x5A) -> press report modifier 0x02, usage 0x1D; with checksum enabled, checksum byte 0x1F, release checksum 0x00.
REQ-029 SHALL verify: send 0x7E -> o_unmapped high for exactly 1 cycle, o_txd stays 1, o_data_ready back to 1 within 3 cycles.
REQ-030 SHALL verify: assert i_rst at the 5th byte's bit 3 -> o_txd=1 the next cycle; then send '0' -> a complete, correct frame with usage 0x27.
REQ-031 SHALL verify: hold i_data_valid high with "ab" queued -> each start bit is exactly 312 cycles wide, o_busy=0 for exactly one cycle between characters, and 4 frames are sent in order.

Source files
------------

// File: rtl/ch9350_keytx.sv
// rtl/ch9350_keytx.sv - ASCII to CH9350 keyboard frame UART transmitter (optional CH9350_KEYTX_CHECKSUM_EN)
module ch9350_keytx #(
    parameter int CLKS_PER_BIT = 312,
    parameter int GAP_BITS     = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_data_valid,
    output logic       o_data_ready,
    output logic       o_txd,
    output logic       o_busy,
    output logic       o_unmapped
);

    localparam int GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
    localparam int CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES - 1);
`ifdef CH9350_KEYTX_CHECKSUM_EN
    localparam logic [3:0] LAST_BYTE = 4'd11;
`else
    localparam logic [3:0] LAST_BYTE = 4'd10;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [7:0]       r_char;
    logic [7:0]       r_mod;
    logic [7:0]       r_usage;
    logic [3:0]       r_byte_idx;
    logic [3:0]       r_bit_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [GAP_W-1:0] r_gap;
    logic             r_release;
    logic             r_txd;
    logic             r_busy;
    logic             r_ready;
    logic             r_unmapped;

    logic             w_map_ok;
    logic [7:0]       w_map_mod;
    logic [7:0]       w_map_usage;
    logic [7:0]       w_byte;
    logic [2:0]       w_sel;
    logic             w_bit;

    // Translate the latched character into HID modifier and usage codes
    always_comb begin
        w_map_ok    = 1'b1;
        w_map_mod   = 8'h00;
        w_map_usage = 8'h00;
        if (r_char >= 8'h61 && r_char <= 8'h7A) begin
            w_map_usage = r_char - 8'h5D;
        end else if (r_char >= 8'h41 && r_char <= 8'h5A) begin
            w_map_usage = r_char - 8'h3D;
            w_map_mod   = 8'h02;
        end else if (r_char >= 8'h31 && r_char <= 8'h39) begin
            w_map_usage = r_char - 8'h13;
        end else begin
            case (r_char)
                8'h30:   w_map_usage = 8'h27;
                8'h0D:   w_map_usage = 8'h28;
                8'h1B:   w_map_usage = 8'h29;
                8'h08:   w_map_usage = 8'h2A;
                8'h09:   w_map_usage = 8'h2B;
                8'h20:   w_map_usage = 8'h2C;
                default: w_map_ok    = 1'b0;
            endcase
        end
    end

    // Select the frame byte currently on the wire and the bit within its 10-bit UART word
    always_comb begin
        w_byte = 8'h00;
        case (r_byte_idx)
            4'd0:    w_byte = 8'h57;
            4'd1:    w_byte = 8'hAB;
            4'd2:    w_byte = 8'h01;
            4'd3:    w_byte = r_mod;
            4'd5:    w_byte = r_usage;
`ifdef CH9350_KEYTX_CHECKSUM_EN
            4'd11:   w_byte = r_mod + r_usage;
`endif
            default: w_byte = 8'h00;
        endcase
        w_sel = r_bit_idx[2:0] - 3'd1;
        if (r_bit_idx == 4'd0) begin
            w_bit = 1'b0;
        end else if (r_bit_idx == 4'd9) begin
            w_bit = 1'b1;
        end else begin
            w_bit = w_byte[w_sel];
        end
    end

    // Keystroke sequencer: press frame, idle gap, release frame, with registered line outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_char     <= 8'h00;
            r_mod      <= 8'h00;
            r_usage    <= 8'h00;
            r_byte_idx <= 4'd0;
            r_bit_idx  <= 4'd0;
            r_cnt      <= '0;
            r_gap      <= '0;
            r_release  <= 1'b0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_unmapped <= 1'b0;
        end else begin
            r_unmapped <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_txd <= 1'b1;
                    if (i_data_valid && r_ready) begin
                        r_char  <= i_data;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (!w_map_ok) begin
                        r_unmapped <= 1'b1;
                        r_busy     <= 1'b0;
                        r_ready    <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_mod      <= w_map_mod;
                        r_usage    <= w_map_usage;
                        r_byte_idx <= 4'd0;
                        r_bit_idx  <= 4'd0;
                        r_cnt      <= '0;
                        r_release  <= 1'b0;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_txd <= w_bit;
                    if (r_cnt == CNT_MAX) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 4'd9) begin
                            r_bit_idx <= 4'd0;
                            if (r_byte_idx == LAST_BYTE) begin
                                r_byte_idx <= 4'd0;
                                if (!r_release) begin
                                    r_mod   <= 8'h00;
                                    r_usage <= 8'h00;
                                    r_gap   <= '0;
                                    r_state <= S_GAP;
                                end else begin
                                    r_state <= S_DONE;
                                end
                            end else begin
                                r_byte_idx <= r_byte_idx + 4'd1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    r_txd <= 1'b1;
                    if (r_gap == GAP_MAX) begin
                        r_release <= 1'b1;
                        r_state   <= S_SEND;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                S_DONE: begin
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_txd        = r_txd;
    assign o_busy       = r_busy;
    assign o_data_ready = r_ready;
    assign o_unmapped   = r_unmapped;

endmodule
